axis_spi_arbiter: RTL and testbench
===================================

// Module: axis_spi_arbiter
// PURPOSE
//  Shares one AXI-Stream SPI serializer (16-cycle SCLK period, 32-bit words, LSB-aligned payload) between
//  NUM_PORTS AXI-Stream requesters (e.g. ADC, clock-chip and DAC configuration writers).
//  Round-robin arbitration, one word per grant. Grant held for the full serial frame plus a guard gap.
//  sel drives the external chip-select/SCLK routing mux.
// PARAMETERS
//  NUM_PORTS       4    number of requester ports, 2..8
//  SPI_DATA_WIDTH  16   serializer frame width in bits, 8..32
//  GAP_CYCLES      32   idle aclk cycles appended after each frame before the next grant, >=1
// PORTS
//  aclk           in   1              system clock; all logic on rising edge
//  areset         in   1              asynchronous, active-high reset
//  s_axis_tdata   in   NUM_PORTS*32   requester words; port i at [32*i+31:32*i]
//  s_axis_tvalid  in   NUM_PORTS      requester valid, one bit per port
//  s_axis_tready  out  NUM_PORTS      one-cycle accept pulse to granted port
//  m_axis_tdata   out  32             word to serializer
//  m_axis_tvalid  out  1              word valid to serializer
//  m_axis_tready  in   1              serializer accept (1-cycle pulse)
//  sel            out  clog2(NUM_PORTS)  index of port owning the SPI bus
//  busy           out  1              high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; sel=0; busy=0;
//    rr_ptr=NUM_PORTS-1 so port 0 wins first. Reset mid-frame aborts: no retry, captured word dropped.
//  - HOLD_CYCLES = (SPI_DATA_WIDTH+1)*16 + GAP_CYCLES, counted from the cycle after m_axis_tready.
//  - FSM, all outputs registered:
//    IDLE : if |s_axis_tvalid: winner = first set bit searching rr_ptr+1, rr_ptr+2, ... (mod NUM_PORTS).
//           Same edge: capture winner word into m_axis_tdata, sel=winner, rr_ptr=winner,
//           s_axis_tready[winner]=1 (1 cycle), m_axis_tvalid=1 -> SEND.
//    SEND : s_axis_tready=0. Hold m_axis_tvalid and m_axis_tdata stable until m_axis_tready=1.
//           On that cycle: m_axis_tvalid=0 next edge, cnt=0 -> HOLD. No timeout.
//    HOLD : cnt++ each cycle; sel frozen; all s_axis_tready=0. At cnt==HOLD_CYCLES-1 -> IDLE.
//  - Latency: tvalid seen in IDLE -> s_axis_tready and m_axis_tvalid high 1 cycle later.
//    Back-to-back grants are separated by exactly HOLD_CYCLES+1 cycles after the downstream accept.
//  - m_axis_tvalid returns 0 the cycle after m_axis_tready. The serializer needs >=1 cycle of
//    tvalid=0 before it frees up, so HOLD guarantees no double capture.
//  - Requester tvalid changes during SEND/HOLD are ignored; no words are lost.
//    A requester must hold tvalid until its tready pulse.
//  - m_axis_tready outside SEND is ignored.
//  - Counter width: clog2(HOLD_CYCLES+1). Never wraps; cleared on entry to HOLD.
//  - s_axis_tready is one-hot or zero at all times.
// STRUCTURE
//  - Package axis_spi_pkg: state encoding localparams (IDLE/SEND/HOLD), SCLK_DIV=16,
//    function hold_cycles(width, gap), and a clog2 helper.
//  - Sub-module rr_priority_pick: combinational round-robin winner from (req, ptr) -> (idx, any).
//    Reused by future SPI-read arbiters.
// TESTING
//  - Reset check, async: assert areset mid-HOLD -> all outputs 0 within the same cycle; busy=0;
//    next request from port 0 granted first.
//  - Single request, port 2, tdata=0x0000_A5C3 -> s_axis_tready=4'b0100 for 1 cycle;
//    m_axis_tdata=0x0000_A5C3; sel=2; busy low 16*17+32+1 cycles after m_axis_tready.
//  - All 4 ports valid continuously -> grant order 0,1,2,3,0. Each sel held for the full frame.
//    No s_axis_tready overlap.
//  - Slow downstream: m_axis_tready delayed 50 cycles -> m_axis_tvalid and tdata stable for
//    51 cycles, then exactly one frame.
//  - Port 1 drops tvalid during HOLD of port 0 and port 3 raises it -> next grant = port 3;
//    port 1 is not granted.
//  - With a serializer model attached: 16-bit frames from 2 ports interleave; SSEL high gap
//    >= GAP_CYCLES between frames; decoded MOSI words match the inputs.

Source files
------------

// File: rtl/axis_spi_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream SPI write arbiter family.
package axis_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int SCLK_DIV   = 16;
  localparam int AXIS_WIDTH = 32;

  // Bus ownership window after the serializer accepts a word: frame plus one spare SCLK period plus guard gap.
  function automatic int hold_cycles(input int width, input int gap);
    return (width + 1) * SCLK_DIV + gap;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_spi_arbiter_if.sv
// Requester/serializer handshake bundle for axis_spi_arbiter; master is the arbiter's view.
interface axis_spi_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  import axis_spi_pkg::*;

  localparam int SEL_W = clog2(NUM_PORTS);

  logic [NUM_PORTS*AXIS_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [AXIS_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [SEL_W-1:0]                sel;
  logic                            busy;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, sel, busy
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, sel, busy
  );

endinterface

// File: rtl/axis_spi_arbiter_rr.sv
// Combinational round-robin pick: the requesting index closest after ptr (wrapping) wins.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Smallest forward distance from ptr wins; ptr itself is the farthest candidate.
  always_comb begin
    int best;
    idx  = '0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (((i - int'(ptr) - 1 + 2 * N) % N) < best)) begin
        best = (i - int'(ptr) - 1 + 2 * N) % N;
        idx  = W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_spi_arbiter.sv
// Round-robin arbiter sharing one SPI serializer among NUM_PORTS AXI-Stream writers, one word per grant.
module axis_spi_arbiter
  import axis_spi_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int SPI_DATA_WIDTH = 16,
  parameter int GAP_CYCLES     = 32
) (
  input logic              aclk,
  input logic              areset,
  axis_spi_arbiter_if.master bus
);

  localparam int SEL_W       = clog2(NUM_PORTS);
  localparam int HOLD_CYCLES = hold_cycles(SPI_DATA_WIDTH, GAP_CYCLES);
  localparam int CNT_W       = clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic [CNT_W-1:0] cnt;

  rr_priority_pick #(.N(NUM_PORTS), .W(SEL_W)) u_pick (
    .req (bus.s_axis_tvalid),
    .ptr (rr_ptr),
    .idx (winner),
    .any (any_req)
  );

  // Reset aborts any frame in flight; the pointer starts at the last port so port 0 wins first.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= IDLE;
      rr_ptr            <= SEL_W'(NUM_PORTS - 1);
      cnt               <= '0;
      bus.s_axis_tready <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.sel           <= '0;
      bus.busy          <= 1'b0;
    end else begin
      bus.s_axis_tready <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.m_axis_tdata          <= bus.s_axis_tdata[int'(winner)*AXIS_WIDTH +: AXIS_WIDTH];
            bus.s_axis_tready[winner] <= 1'b1;
            bus.m_axis_tvalid         <= 1'b1;
            bus.sel                   <= winner;
            bus.busy                  <= 1'b1;
            rr_ptr                    <= winner;
            state                     <= SEND;
          end
        end
        SEND: begin
          if (bus.m_axis_tready) begin
            bus.m_axis_tvalid <= 1'b0;
            cnt               <= '0;
            state             <= HOLD;
          end
        end
        HOLD: begin
          // The serializer is still shifting; sel and the grant stay frozen until the gap expires.
          if (cnt == CNT_LAST) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Self-checking bench for axis_spi_arbiter: directed table, hand sequences, then a randomized run vs a timeline model.
module tb_axis_spi_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 16;
  localparam int GAP = 32;
  localparam int H   = (DW + 1) * 16 + GAP;
  localparam int RAND_CYCLES = 12000;

  typedef struct {
    logic [NP-1:0] req;
    int            winner;
    logic [31:0]   data;
    int            delay;
  } vec_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axis_spi_arbiter_if #(.NUM_PORTS(NP)) bus ();

  axis_spi_arbiter #(
    .NUM_PORTS      (NP),
    .SPI_DATA_WIDTH (DW),
    .GAP_CYCLES     (GAP)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  vec_t        vecs [11];
  int          port, waited, w, c, srl_wait, m_ptr, m_sel, m_free, grants;
  bit          m_sending, mrdy_prev;
  logic [31:0] m_data;
  logic [31:0] words [NP];
  logic [NP-1:0] req, req_prev, exp_tready;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive_words();
    for (int i = 0; i < NP; i++) bus.s_axis_tdata[32*i +: 32] = words[i];
  endtask

  task automatic wait_grant(input int budget, output int gport, output int gwait);
    int k;
    gport = -1;
    gwait = 0;
    k = 0;
    while (gport < 0 && k < budget) begin
      @(negedge aclk);
      k++;
      for (int i = 0; i < NP; i++) begin
        if (bus.s_axis_tready[i]) begin
          gport = i;
          gwait = k;
        end
      end
    end
  endtask

  // Serializer side: keep tready low for 'delay' cycles, pulse it, then time the bus hold.
  task automatic accept_and_measure(input int delay, input logic [31:0] word, input int gport);
    int stable, k;
    bit done;
    stable = 0;
    for (int d = 1; d <= delay; d++) begin
      @(negedge aclk);
      if (d == 1) checkOutput("tready_pulse", 32'(bus.s_axis_tready), 32'd0);
      if (bus.m_axis_tvalid && bus.m_axis_tdata == word && 32'(bus.sel) == 32'(gport)) stable++;
    end
    if (delay > 0) checkOutput("stable_cycles", 32'(stable), 32'(delay));
    bus.m_axis_tready = 1'b1;
    done = 1'b0;
    k = 0;
    while (!done && k < H + 20) begin
      @(negedge aclk);
      k++;
      if (k == 1) begin
        bus.m_axis_tready = 1'b0;
        checkOutput("tvalid_drop", 32'(bus.m_axis_tvalid), 32'd0);
      end
      if (k == H / 2) checkOutput("sel_frozen", 32'(bus.sel), 32'(gport));
      if (!bus.busy) done = 1'b1;
    end
    checkOutput("hold_len", 32'(k), 32'(H + 1));
  endtask

  task automatic applyStimulus(input vec_t v);
    int gp, gw;
    for (int i = 0; i < NP; i++) words[i] = (i == v.winner) ? v.data : ~v.data;
    drive_words();
    bus.s_axis_tvalid = v.req;
    wait_grant(8, gp, gw);
    checkOutput("grant_port", 32'(gp), 32'(v.winner));
    checkOutput("grant_latency", 32'(gw), 32'd1);
    checkOutput("tready_onehot", 32'(bus.s_axis_tready), 32'd1 << v.winner);
    checkOutput("m_tdata", bus.m_axis_tdata, v.data);
    checkOutput("sel", 32'(bus.sel), 32'(v.winner));
    checkOutput("busy_on", 32'(bus.busy), 32'd1);
    bus.s_axis_tvalid = '0;
    accept_and_measure(v.delay, v.data, v.winner);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'b0100, 2, 32'h0000_A5C3, 1};
    vecs[1]  = '{4'b1111, 3, 32'h1234_5678, 2};
    vecs[2]  = '{4'b1111, 0, 32'hDEAD_BEEF, 3};
    vecs[3]  = '{4'b1111, 1, 32'h0000_FFFF, 1};
    vecs[4]  = '{4'b0011, 0, 32'h8000_0001, 4};
    vecs[5]  = '{4'b0011, 1, 32'h5555_AAAA, 1};
    vecs[6]  = '{4'b1000, 3, 32'h0F0F_0F0F, 2};
    vecs[7]  = '{4'b0101, 0, 32'h1357_9BDF, 1};
    vecs[8]  = '{4'b0101, 2, 32'h2468_ACE0, 5};
    vecs[9]  = '{4'b0001, 0, 32'h0000_0001, 1};
    vecs[10] = '{4'b1000, 3, 32'hFFFF_FFFF, 1};

    areset = 1'b1;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < NP; i++) words[i] = '0;
    repeat (3) @(negedge aclk);
    checkOutput("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    checkOutput("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    checkOutput("rst_tdata", bus.m_axis_tdata, 32'd0);
    checkOutput("rst_sel", 32'(bus.sel), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    areset = 1'b0;

    $display("[TB] directed table");
    for (int v = 0; v < 11; v++) applyStimulus(vecs[v]);

    $display("[TB] port 1 drops and port 3 raises during hold");
    words[0] = 32'hC0DE_0000;
    words[1] = 32'hC0DE_0001;
    words[3] = 32'hC0DE_0003;
    drive_words();
    bus.s_axis_tvalid = 4'b0011;
    wait_grant(8, port, waited);
    checkOutput("drop_first_grant", 32'(port), 32'd0);
    bus.s_axis_tvalid = 4'b0010;
    bus.m_axis_tready = 1'b1;
    for (int k = 1; k <= H + 20 && (k < 3 || bus.busy); k++) begin
      @(negedge aclk);
      if (k == 1) bus.m_axis_tready = 1'b0;
      if (k == 10) bus.s_axis_tvalid = 4'b1000;
    end
    wait_grant(4, port, waited);
    checkOutput("drop_next_grant", 32'(port), 32'd3);
    checkOutput("drop_gap", 32'(waited), 32'd1);
    checkOutput("drop_tdata", bus.m_axis_tdata, 32'hC0DE_0003);
    bus.s_axis_tvalid = '0;
    accept_and_measure(1, 32'hC0DE_0003, 3);

    $display("[TB] slow downstream");
    words[1] = 32'hB0B0_1111;
    drive_words();
    bus.s_axis_tvalid = 4'b0010;
    wait_grant(8, port, waited);
    checkOutput("slow_grant", 32'(port), 32'd1);
    bus.s_axis_tvalid = '0;
    accept_and_measure(50, 32'hB0B0_1111, 1);

    $display("[TB] async reset mid-hold");
    words[2] = 32'h7777_2222;
    drive_words();
    bus.s_axis_tvalid = 4'b0100;
    wait_grant(8, port, waited);
    checkOutput("arst_grant", 32'(port), 32'd2);
    bus.s_axis_tvalid = '0;
    bus.m_axis_tready = 1'b1;
    @(negedge aclk);
    bus.m_axis_tready = 1'b0;
    repeat (20) @(negedge aclk);
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    checkOutput("arst_tready", 32'(bus.s_axis_tready), 32'd0);
    checkOutput("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    checkOutput("arst_tdata", bus.m_axis_tdata, 32'd0);
    checkOutput("arst_sel", 32'(bus.sel), 32'd0);
    checkOutput("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge aclk);
    areset = 1'b0;

    $display("[TB] all ports valid continuously");
    for (int i = 0; i < NP; i++) words[i] = 32'hA000_0000 | 32'(i);
    drive_words();
    bus.s_axis_tvalid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(H + 10, port, waited);
      checkOutput("rr_order", 32'(port), 32'(g % NP));
      checkOutput("rr_gap", 32'(waited), 32'd1);
      checkOutput("rr_tdata", bus.m_axis_tdata, 32'hA000_0000 | 32'(g % NP));
      accept_and_measure(1, 32'hA000_0000 | 32'(g % NP), g % NP);
    end
    bus.s_axis_tvalid = '0;

    $display("[TB] randomized run against timeline model");
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    req = '0;
    req_prev = '0;
    mrdy_prev = 1'b0;
    bus.m_axis_tready = 1'b0;
    srl_wait = -1;
    m_sending = 1'b0;
    m_ptr = NP - 1;
    m_sel = 0;
    m_data = '0;
    m_free = 0;
    grants = 0;
    for (int cyc = 1; cyc <= RAND_CYCLES; cyc++) begin
      @(negedge aclk);
      exp_tready = '0;
      if (m_sending) begin
        if (mrdy_prev) begin
          m_sending = 1'b0;
          m_free = cyc + H + 1;
        end
      end else if (cyc >= m_free && req_prev != '0) begin
        w = -1;
        for (int d = 1; d <= NP; d++) begin
          c = (m_ptr + d) % NP;
          if (w < 0 && req_prev[c]) w = c;
        end
        m_ptr = w;
        m_sel = w;
        m_data = words[w];
        m_sending = 1'b1;
        exp_tready[w] = 1'b1;
        grants++;
      end
      checkOutput("rnd_tready", 32'(bus.s_axis_tready), 32'(exp_tready));
      checkOutput("rnd_tvalid", 32'(bus.m_axis_tvalid), 32'(m_sending));
      checkOutput("rnd_tdata", bus.m_axis_tdata, m_data);
      checkOutput("rnd_sel", 32'(bus.sel), 32'(m_sel));
      checkOutput("rnd_busy", 32'(bus.busy), 32'(m_sending || (cyc < m_free - 1)));

      for (int i = 0; i < NP; i++) begin
        if (bus.s_axis_tready[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 99) < 2) begin
          req[i] = 1'b1;
          words[i] = $urandom;
        end
      end
      if (bus.m_axis_tready) bus.m_axis_tready = 1'b0;
      else if (bus.m_axis_tvalid) begin
        if (srl_wait < 0) srl_wait = $urandom_range(0, 6);
        else if (srl_wait == 0) begin
          bus.m_axis_tready = 1'b1;
          srl_wait = -1;
        end else srl_wait--;
      end else if ($urandom_range(0, 99) < 3) bus.m_axis_tready = 1'b1;
      drive_words();
      bus.s_axis_tvalid = req;
      req_prev = req;
      mrdy_prev = bus.m_axis_tready;
    end
    $display("[TB] randomized run granted %0d words", grants);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
